// File: rtl/calc_host_driver.sv
// rtl/calc_host_driver.sv - host driver that serializes a 16-bit calculator request and collects the 2-byte result (optional timeout: CALC_HOST_TIMEOUT_EN)
module calc_host_driver #(
    parameter int OP_W           = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [15:0]     req_a,
    input  logic [15:0]     req_b,
    output logic [7:0]      bus_data,
    output logic            bus_valid,
    input  logic            bus_ready,
    input  logic [7:0]      res_data,
    input  logic            res_valid,
    output logic            rsp_valid,
    output logic [15:0]     rsp_result,
    output logic            rsp_err,
    output logic            busy
);

    // Configuration sanity: an out-of-range timeout shows up as this named empty block.
    if (TIMEOUT_CYCLES >= (1 << TO_CNT_W)) begin : g_timeout_cfg_out_of_range
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  hi_q;
    logic [7:0]  bus_data_q;
    logic        bus_valid_q;
    logic        req_ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_result_q;
    logic [7:0]  next_byte_d;

`ifdef CALC_HOST_TIMEOUT_EN
    logic [TO_CNT_W-1:0] cnt_q;
    logic                rsp_err_q;
    logic                timeout_hit;

    assign timeout_hit = (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = rsp_err_q;
`else
    assign rsp_err     = 1'b0;
`endif

    // Frame byte that follows the one currently on the bus (index idx_q + 1).
    always_comb begin
        next_byte_d = 8'h00;
        case (idx_q)
            3'd0:    next_byte_d = a_q[15:8];
            3'd1:    next_byte_d = a_q[7:0];
            3'd2:    next_byte_d = b_q[15:8];
            3'd3:    next_byte_d = b_q[7:0];
            default: next_byte_d = 8'h00;
        endcase
    end

    // Request/serialize/collect FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            hi_q         <= 8'h00;
            bus_data_q   <= 8'h00;
            bus_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 16'h0000;
`ifdef CALC_HOST_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        idx_q       <= 3'd0;
                        bus_data_q  <= 8'(req_op);
                        bus_valid_q <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SEND;
`ifdef CALC_HOST_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                    end
                end
                S_SEND: begin
                    // bus_data only advances on an accepted byte, so it is stable under stall.
                    if (bus_ready) begin
                        if (idx_q == 3'd4) begin
                            bus_valid_q <= 1'b0;
                            bus_data_q  <= 8'h00;
                            idx_q       <= 3'd0;
                            state_q     <= S_WAIT_HI;
`ifdef CALC_HOST_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end else begin
                            idx_q      <= idx_q + 3'd1;
                            bus_data_q <= next_byte_d;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (res_valid) begin
                        hi_q    <= res_data;
                        state_q <= S_WAIT_LO;
`ifdef CALC_HOST_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (timeout_hit) begin
                        rsp_result_q <= 16'hFFFF;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                S_WAIT_LO: begin
                    // Result is published whole so rsp_result never shows a half-updated value.
                    if (res_valid) begin
                        rsp_result_q <= {hi_q, res_data};
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
`ifdef CALC_HOST_TIMEOUT_EN
                        cnt_q        <= '0;
                    end else if (timeout_hit) begin
                        rsp_result_q <= 16'hFFFF;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    bus_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign bus_data   = bus_data_q;
    assign bus_valid  = bus_valid_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;

endmodule
